// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in flight, and
// presents {inst, pc} to decode. Redirects from execute discard stale responses.
module ifu_fetch #(
  parameter int unsigned           PC_WIDTH   = 64,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = 64'h8000_0000,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [63:0]           fetch_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic                drop;
  logic                req_fire;
  logic [PC_WIDTH-1:0] redir_target;

  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid & imem_req_ready;
  assign redir_target  = redirect_pc & ~PC_WIDTH'(3);

  // imem_req_valid is registered so it stays low through the reset cycle and
  // rises on the first edge after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      out_valid      <= 1'b0;
      out_inst       <= NOP_INST;
      out_pc         <= RESET_PC;
      fetch_cnt      <= '0;
    end else begin
      if (redirect_valid)
        pc <= redir_target;

      case (state)
        S_REQ: begin
          if (req_fire) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
            if (redirect_valid)
              drop <= 1'b1;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end

        S_WAIT: begin
          if (imem_resp_valid) begin
            if (!drop && !redirect_valid) begin
              out_inst  <= imem_resp_data;
              out_pc    <= pc;
              out_valid <= 1'b1;
              state     <= S_HOLD;
            end else begin
              drop           <= 1'b0;
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end

        S_HOLD: begin
          if (out_ready)
            fetch_cnt <= fetch_cnt + 64'd1;
          // A redirect leaves S_HOLD even without out_ready; its pc already took priority above.
          if (redirect_valid || out_ready) begin
            if (!redirect_valid)
              pc <= pc + PC_WIDTH'(4);
            state          <= S_REQ;
            out_valid      <= 1'b0;
            out_inst       <= NOP_INST;
            imem_req_valid <= 1'b1;
          end
        end

        default: begin
          state          <= S_REQ;
          out_valid      <= 1'b0;
          out_inst       <= NOP_INST;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: one task per scenario, inline checks, hand-computed values.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [63:0] fetch_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  ifu_fetch #(
    .PC_WIDTH   (64),
    .INST_WIDTH (32),
    .RESET_PC   (64'h8000_0000),
    .NOP_INST   (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .fetch_cnt       (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change here, outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b0;
    step(); step();
    total_cnt++;
    if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %0b want 0", imem_req_valid); else pass_cnt++;
    total_cnt++;
    if (out_pc !== 64'h8000_0000) $display("FAIL rst_out_pc got %h want 80000000", out_pc); else pass_cnt++;
    total_cnt++;
    if (fetch_cnt !== 64'd0) $display("FAIL rst_fetch_cnt got %0d want 0", fetch_cnt); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if (imem_req_valid !== 1'b1) $display("FAIL t1_req_valid got %0b want 1", imem_req_valid); else pass_cnt++;
    total_cnt++;
    if (imem_req_addr !== 64'h8000_0000) $display("FAIL t1_addr got %h want 80000000", imem_req_addr); else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL t1_out_valid got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_inst !== 32'h0000_0013) $display("FAIL t1_out_inst got %h want 00000013", out_inst); else pass_cnt++;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    total_cnt++;
    if (imem_req_valid !== 1'b0) $display("FAIL t2_wait_req_valid got %0b want 0", imem_req_valid); else pass_cnt++;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093; step(); imem_resp_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL t2_out_valid0 got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_inst !== 32'h0010_0093) $display("FAIL t2_inst0 got %h want 00100093", out_inst); else pass_cnt++;
    total_cnt++;
    if (out_pc !== 64'h8000_0000) $display("FAIL t2_pc0 got %h want 80000000", out_pc); else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0000_0013) $display("FAIL t2_after_fire got valid=%0b inst=%h want 0/00000013", out_valid, out_inst); else pass_cnt++;
    total_cnt++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) $display("FAIL t2_req1 got valid=%0b addr=%h want 1/80000004", imem_req_valid, imem_req_addr); else pass_cnt++;
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0113; step(); imem_resp_valid = 1'b0;
    total_cnt++;
    if (out_inst !== 32'h0020_0113 || out_pc !== 64'h8000_0004) $display("FAIL t2_out1 got inst=%h pc=%h want 00200113/80000004", out_inst, out_pc); else pass_cnt++;
    step();
    total_cnt++;
    if (fetch_cnt !== 64'd2) $display("FAIL t2_fetch_cnt got %0d want 2", fetch_cnt); else pass_cnt++;
    total_cnt++;
    if (imem_req_addr !== 64'h8000_0008) $display("FAIL t2_next_addr got %h want 80000008", imem_req_addr); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0030_0193; step(); imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || out_inst !== 32'h0030_0193 || out_pc !== 64'h8000_0008 ||
          imem_req_valid !== 1'b0 || fetch_cnt !== 64'd2)
        $display("FAIL t3_hold%0d got v=%0b inst=%h pc=%h req=%0b cnt=%0d want 1/00300193/80000008/0/2",
                 i, out_valid, out_inst, out_pc, imem_req_valid, fetch_cnt);
      else pass_cnt++;
    end
    out_ready = 1'b1; step();
    total_cnt++;
    if (fetch_cnt !== 64'd3 || imem_req_addr !== 64'h8000_000c) $display("FAIL t3_release got cnt=%0d addr=%h want 3/8000000c", fetch_cnt, imem_req_addr); else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; step(); redirect_valid = 1'b0;
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef; step(); imem_resp_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0000_0013) $display("FAIL t4_dropped got v=%0b inst=%h want 0/00000013", out_valid, out_inst); else pass_cnt++;
    total_cnt++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) $display("FAIL t4_req got v=%0b addr=%h want 1/80000100", imem_req_valid, imem_req_addr); else pass_cnt++;
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0040_0213; step(); imem_resp_valid = 1'b0;
    total_cnt++;
    if (out_pc !== 64'h8000_0100 || out_inst !== 32'h0040_0213) $display("FAIL t4_out got pc=%h inst=%h want 80000100/00400213", out_pc, out_inst); else pass_cnt++;
    step();
    total_cnt++;
    if (fetch_cnt !== 64'd4) $display("FAIL t4_cnt got %0d want 4", fetch_cnt); else pass_cnt++;
  endtask

  task automatic test_redirect_resp();
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0293;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; step();
    imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL t5_dropped got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) $display("FAIL t5_req got v=%0b addr=%h want 1/80000100", imem_req_valid, imem_req_addr); else pass_cnt++;
  endtask

  task automatic test_redirect_hold();
    out_ready = 1'b0;
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0060_0313; step(); imem_resp_valid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; out_ready = 1'b1; step();
    redirect_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || fetch_cnt !== 64'd5) $display("FAIL jump_retire got v=%0b cnt=%0d want 0/5", out_valid, fetch_cnt); else pass_cnt++;
    total_cnt++;
    if (imem_req_addr !== 64'h8000_0200) $display("FAIL jump_addr got %h want 80000200", imem_req_addr); else pass_cnt++;
    // Redirect coinciding with a firing request: the old fetch must be discarded.
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; step();
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    total_cnt++;
    if (imem_req_valid !== 1'b0) $display("FAIL req_redir_wait got %0b want 0", imem_req_valid); else pass_cnt++;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0070_0393; step(); imem_resp_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || imem_req_addr !== 64'h8000_0300) $display("FAIL req_redir_drop got v=%0b addr=%h want 0/80000300", out_valid, imem_req_addr); else pass_cnt++;
  endtask

  task automatic test_pc_wrap();
    redirect_valid = 1'b1; redirect_pc = 64'hffff_ffff_ffff_ffff; step(); redirect_valid = 1'b0;
    total_cnt++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hffff_ffff_ffff_fffc) $display("FAIL wrap_redir got v=%0b addr=%h want 1/fffffffffffffffc", imem_req_valid, imem_req_addr); else pass_cnt++;
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0080_0413; out_ready = 1'b1; step(); imem_resp_valid = 1'b0;
    total_cnt++;
    if (out_pc !== 64'hffff_ffff_ffff_fffc) $display("FAIL wrap_out_pc got %h want fffffffffffffffc", out_pc); else pass_cnt++;
    step();
    total_cnt++;
    if (imem_req_addr !== 64'd0 || fetch_cnt !== 64'd6) $display("FAIL wrap_next got addr=%h cnt=%0d want 0/6", imem_req_addr, fetch_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_wait();
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0090_0493; step(); imem_resp_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || fetch_cnt !== 64'd0) $display("FAIL t6_ignored got v=%0b cnt=%0d want 0/0", out_valid, fetch_cnt); else pass_cnt++;
    total_cnt++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) $display("FAIL t6_restart got v=%0b addr=%h want 1/80000000", imem_req_valid, imem_req_addr); else pass_cnt++;
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00a0_0513; step(); imem_resp_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_inst !== 32'h00a0_0513 || out_pc !== 64'h8000_0000) $display("FAIL t6_refetch got v=%0b inst=%h pc=%h want 1/00a00513/80000000", out_valid, out_inst, out_pc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_redirect_hold();
    test_pc_wrap();
    test_reset_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
